// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package arm_seq_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int IDX_W = $clog2(NREGS);
  localparam int CNT_W = $clog2(NREGS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2
  } seq_state_t;

  // Instruction field positions.
  localparam int OP_MSB   = 27;
  localparam int OP_LSB   = 25;
  localparam int P_BIT    = 24;
  localparam int U_BIT    = 23;
  localparam int W_BIT    = 21;
  localparam int L_BIT    = 20;
  localparam int RN_MSB   = 19;
  localparam int RN_LSB   = 16;
  localparam int LIST_MSB = 15;
  localparam int LIST_LSB = 0;

  localparam logic [2:0] BLOCK_OP   = 3'b100;
  localparam int         WORD_BYTES = 4;

  // Byte span covered by n word transfers, modulo 2^XLEN.
  function automatic logic [XLEN-1:0] span_bytes(input logic [CNT_W-1:0] n);
    return XLEN'(n) * XLEN'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Decoder/datapath side bundle of the block-transfer sequencer.
// master: the sequencer itself. slave: the decoder/datapath that feeds it.
interface ldm_stm_sequencer_if;
  import arm_seq_pkg::*;

  logic [31:0]      instr;
  logic             cond_ex;
  logic [XLEN-1:0]  base_data;
  logic             stall;
  logic             busy;
  logic [XLEN-1:0]  mem_addr;
  logic             mem_write;
  logic             reg_write;
  logic [IDX_W-1:0] reg_addr;
  logic             wb_en;
  logic [XLEN-1:0]  wb_data;

  modport master (
    input  instr, cond_ex, base_data,
    output stall, busy, mem_addr, mem_write, reg_write, reg_addr, wb_en, wb_data
  );

  modport slave (
    output instr, cond_ex, base_data,
    input  stall, busy, mem_addr, mem_write, reg_write, reg_addr, wb_en, wb_data
  );

endinterface

// File: rtl/ldm_stm_sequencer_reg_list_scan.sv
// Combinational register-list scanner: index of the lowest set bit and
// number of set bits. low_idx is 0 for an empty list.
module reg_list_scan
  import arm_seq_pkg::*;
(
  input  logic [NREGS-1:0] list,
  output logic [IDX_W-1:0] low_idx,
  output logic [CNT_W-1:0] count
);

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    low_idx = '0;
    count   = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      // NOTE: blocking assignments here, so each iteration sees the previous one's result.
      if (list[i]) low_idx = IDX_W'(i);
      count = count + CNT_W'(list[i]);
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks the register list one register per cycle,
// driving register/memory address and strobes, with optional base writeback.
// Build option: define SEQ_WRITEBACK_EN to honour the W bit and enable the
// WB state; otherwise W is ignored and wb_en/wb_data stay 0.
module ldm_stm_sequencer
  import arm_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  ldm_stm_sequencer_if.master  bus
);

  seq_state_t       state, state_nx;
  logic [NREGS-1:0] list_q;
  logic [XLEN-1:0]  cur_addr_q;
  logic             l_q;

  // Instruction fields as seen in the start cycle.
  logic [NREGS-1:0] instr_list;
  logic [IDX_W-1:0] instr_rn;
  logic             instr_p, instr_u, instr_l;
  logic             start;

  assign instr_list = bus.instr[LIST_MSB:LIST_LSB];
  assign instr_rn   = bus.instr[RN_MSB:RN_LSB];
  assign instr_p    = bus.instr[P_BIT];
  assign instr_u    = bus.instr[U_BIT];
  assign instr_l    = bus.instr[L_BIT];
  assign start      = (state == IDLE) && (bus.instr[OP_MSB:OP_LSB] == BLOCK_OP)
                      && bus.cond_ex && (|instr_list);

  // One scanner serves both phases: the fresh list in IDLE (for n), the
  // remaining list in XFER (for the next register and last-transfer detect).
  logic [NREGS-1:0] scan_list;
  logic [IDX_W-1:0] scan_idx;
  logic [CNT_W-1:0] scan_count;
  logic             last_xfer;

  assign scan_list = (state == IDLE) ? instr_list : list_q;
  assign last_xfer = (state == XFER) && (scan_count == CNT_W'(1));

  reg_list_scan u_scan (
    .list    (scan_list),
    .low_idx (scan_idx),
    .count   (scan_count)
  );

  // Lowest address of the block; ascending registers always map upwards.
  logic [XLEN-1:0] span;
  logic [XLEN-1:0] first_addr;
  assign span = span_bytes(scan_count);

  always_comb begin
    first_addr = bus.base_data;
    unique case ({instr_p, instr_u})
      2'b01:   first_addr = bus.base_data;
      2'b11:   first_addr = bus.base_data + XLEN'(WORD_BYTES);
      2'b00:   first_addr = bus.base_data - span + XLEN'(WORD_BYTES);
      default: first_addr = bus.base_data - span;
    endcase
  end

`ifdef SEQ_WRITEBACK_EN
  logic [XLEN-1:0]  wb_val_q;
  logic [IDX_W-1:0] rn_q;
  logic             wb_go_q;
  logic             wb_go_d;
  logic             unused_bits;

  // A load that overwrites its own base keeps the loaded value.
  assign wb_go_d     = bus.instr[W_BIT] && !(instr_l && instr_list[instr_rn]);
  assign unused_bits = &{1'b0, bus.instr[31:28], bus.instr[22]};

  // Writeback bookkeeping, captured once in the start cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_val_q <= '0;
      rn_q     <= '0;
      wb_go_q  <= 1'b0;
    end else if (start) begin
      wb_val_q <= instr_u ? (bus.base_data + span) : (bus.base_data - span);
      rn_q     <= instr_rn;
      wb_go_q  <= wb_go_d;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.instr[31:28], bus.instr[22:21], instr_rn};
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    else       state <= state_nx;
  end

  // Remaining list and running address: loaded at start, stepped per transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      list_q     <= '0;
      cur_addr_q <= '0;
      l_q        <= 1'b0;
    end else if (start) begin
      list_q     <= instr_list;
      cur_addr_q <= first_addr;
      l_q        <= instr_l;
    end else if (state == XFER) begin
      list_q[scan_idx] <= 1'b0;
      cur_addr_q       <= cur_addr_q + XLEN'(WORD_BYTES);
    end
  end

  // Next-state and output decode; only stall looks at instr, in IDLE.
  always_comb begin
    state_nx      = state;
    bus.stall     = 1'b0;
    bus.busy      = (state != IDLE);
    bus.mem_addr  = '0;
    bus.mem_write = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_addr  = '0;
    bus.wb_en     = 1'b0;
    bus.wb_data   = '0;
    unique case (state)
      IDLE: begin
        // A non-empty list means the start cycle is never the last one.
        bus.stall = start && !reset;
        if (start) state_nx = XFER;
      end
      XFER: begin
        bus.reg_addr  = scan_idx;
        bus.mem_addr  = cur_addr_q;
        bus.reg_write = l_q;
        bus.mem_write = !l_q;
`ifdef SEQ_WRITEBACK_EN
        bus.stall = !last_xfer || wb_go_q;
        if (last_xfer) state_nx = wb_go_q ? WB : IDLE;
`else
        bus.stall = !last_xfer;
        if (last_xfer) state_nx = IDLE;
`endif
      end
`ifdef SEQ_WRITEBACK_EN
      WB: begin
        bus.reg_addr = rn_q;
        bus.wb_en    = 1'b1;
        bus.wb_data  = wb_val_q;
        state_nx     = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

endmodule
